// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot loader: FSM encoding and header field layout.
package loader_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD_I = 3'd2;
    localparam logic [2:0] S_LOAD_D = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int NI_HI = 31;
    localparam int NI_LO = 16;
    localparam int ND_HI = 15;
    localparam int ND_LO = 0;

endpackage

// File: rtl/prog_loader.sv
// Hardware boot loader: clears IMEM/DMEM, streams in instruction and data images,
// then holds the CPU start line high.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_BYTES = 32,
    parameter int IA_W       = 8,
    parameter int DA_W       = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    input  logic [31:0]     in_data_i,
    output logic            in_ready_o,
    output logic            imem_we_o,
    output logic [IA_W-1:0] imem_addr_o,
    output logic [31:0]     imem_data_o,
    output logic            dmem_we_o,
    output logic [DA_W-1:0] dmem_addr_o,
    output logic [31:0]     dmem_data_o,
    output logic            start_o,
    output logic            busy_o,
    output logic            error_o
);

    localparam int DWORDS = DMEM_BYTES / 4;
    // One extra bit so a count of IMEM_DEPTH is representable without wrap.
    localparam int CW = IA_W + 1;
    localparam logic [15:0]   NI_MAX   = 16'(IMEM_DEPTH);
    localparam logic [15:0]   ND_MAX   = 16'(DWORDS);
    localparam logic [CW-1:0] CLR_LAST = CW'(IMEM_DEPTH - 1);

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, ni_q, ni_d, nd_q, nd_d;
    logic            ready_q, ready_d;
    logic            imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
    logic [IA_W-1:0] imem_addr_q, imem_addr_d;
    logic [DA_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]     imem_data_q, imem_data_d, dmem_data_q, dmem_data_d;
    logic            start_q, start_d, busy_q, busy_d, error_q, error_d;

    logic [15:0]     hdr_ni, hdr_nd;
    logic            xfer;
    logic [CW-1:0]   cnt_inc;
    logic [DA_W-1:0] cnt_baddr;

    assign hdr_ni    = in_data_i[NI_HI:NI_LO];
    assign hdr_nd    = in_data_i[ND_HI:ND_LO];
    assign xfer      = in_valid_i & ready_q;
    assign cnt_inc   = cnt_q + CW'(1);
    assign cnt_baddr = {cnt_q[DA_W-3:0], 2'b00};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ni_d        = ni_q;
        nd_d        = nd_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        dmem_we_d   = 1'b0;
        dmem_addr_d = dmem_addr_q;
        dmem_data_d = dmem_data_q;
        start_d     = start_q;
        busy_d      = busy_q;
        error_d     = error_q;
        case (state_q)
            S_IDLE: if (xfer) begin
                if (hdr_ni > NI_MAX || hdr_nd > ND_MAX) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    ni_d    = CW'(hdr_ni);
                    nd_d    = CW'(hdr_nd);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                imem_we_d   = 1'b1;
                imem_addr_d = cnt_q[IA_W-1:0];
                imem_data_d = '0;
                if (cnt_q < CW'(DWORDS)) begin
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = cnt_baddr;
                    dmem_data_d = '0;
                end
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = (ni_q != '0) ? S_LOAD_I :
                              (nd_q != '0) ? S_LOAD_D : S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOAD_I: if (xfer) begin
                imem_we_d   = 1'b1;
                imem_addr_d = cnt_q[IA_W-1:0];
                imem_data_d = in_data_i;
                if (cnt_inc == ni_q) begin
                    cnt_d   = '0;
                    state_d = (nd_q != '0) ? S_LOAD_D : S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOAD_D: if (xfer) begin
                dmem_we_d   = 1'b1;
                dmem_addr_d = cnt_baddr;
                dmem_data_d = in_data_i;
                if (cnt_inc == nd_q) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN:   start_d = 1'b1;
            S_ERR:   ;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_I) || (state_d == S_LOAD_D);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ni_q        <= '0;
            nd_q        <= '0;
            ready_q     <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ni_q        <= ni_d;
            nd_q        <= nd_d;
            ready_q     <= ready_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_data_q <= dmem_data_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign imem_we_o   = imem_we_q;
    assign imem_addr_o = imem_addr_q;
    assign imem_data_o = imem_data_q;
    assign dmem_we_o   = dmem_we_q;
    assign dmem_addr_o = dmem_addr_q;
    assign dmem_data_o = dmem_data_q;
    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: write monitor feeds a memory model checked against hand values.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, imem_we, dmem_we, start, busy, error;
    logic [7:0]  imem_addr;
    logic [4:0]  dmem_addr;
    logic [31:0] imem_data, dmem_data;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
        .imem_data_o(imem_data), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_data_o(dmem_data), .start_o(start), .busy_o(busy), .error_o(error)
    );

    int nchk = 0, nerr = 0;
    int cyc = 0;
    logic [31:0] imem_m [256];
    logic [31:0] dmem_m [8];
    logic [31:0] iw_addr [$];
    logic [31:0] iw_data [$];
    int iw_cnt = 0, dw_cnt = 0, dw_misalign = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are captured mid-cycle; each write-enable pulse spans exactly one negedge.
    always @(negedge clk) begin
        if (imem_we) begin
            imem_m[imem_addr] = imem_data;
            iw_addr.push_back({24'd0, imem_addr});
            iw_data.push_back(imem_data);
            iw_cnt++;
        end
        if (dmem_we) begin
            dmem_m[dmem_addr[4:2]] = dmem_data;
            if (dmem_addr[1:0] != 2'b00) dw_misalign++;
            dw_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) imem_m[i] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) dmem_m[i] = 32'hDEADBEEF;
        iw_addr.delete();
        iw_data.delete();
        iw_cnt = 0;
        dw_cnt = 0;
        dw_misalign = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Leaves in_valid high on return; the transfer edge has just passed.
    task automatic send(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("send_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic wait_start(output int edges);
        int n = 0;
        while (!start && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) check("start_timeout", 32'd0, 32'd1);
        edges = n;
    endtask

    function automatic int imem_nonzero(input int from);
        int c = 0;
        for (int i = from; i < 256; i++) if (imem_m[i] !== 32'd0) c++;
        return c;
    endfunction

    function automatic int dmem_nonzero(input int from);
        int c = 0;
        for (int i = from; i < 8; i++) if (dmem_m[i] !== 32'd0) c++;
        return c;
    endfunction

    initial begin
        int t0, n, k;
        bit rdy_seen, start_drop;
        logic [31:0] w2 [2];

        // Reset state
        step();
        check("rst_outs", {31'd0, |{in_ready, imem_we, imem_addr, imem_data, dmem_we,
                                    dmem_addr, dmem_data, start, busy, error}}, 32'd0);
        do_reset();
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // Test 1: NI=3, ND=1 at full rate
        fill_mem();
        send(32'h0003_0001);
        t0 = cyc;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_clr", {31'd0, in_ready}, 32'd0);
        in_data = 32'hA0A0_0001; while (!in_ready) step(); step();
        in_data = 32'hB0B0_0002; step();
        in_data = 32'hC0C0_0003; step();
        in_data = 32'h0000_0005; step();
        in_valid = 1'b0;
        wait_start(n);
        check("t1_latency", cyc - t0, 32'd262);
        check("t1_iw_cnt", iw_cnt, 32'd259);
        check("t1_dw_cnt", dw_cnt, 32'd9);
        check("t1_clr_first", iw_addr[0], 32'd0);
        check("t1_clr_last", iw_addr[255], 32'd255);
        check("t1_imem0", imem_m[0], 32'hA0A0_0001);
        check("t1_imem1", imem_m[1], 32'hB0B0_0002);
        check("t1_imem2", imem_m[2], 32'hC0C0_0003);
        check("t1_imem_rest", imem_nonzero(3), 32'd0);
        check("t1_dmem0", dmem_m[0], 32'd5);
        check("t1_dmem_rest", dmem_nonzero(1), 32'd0);
        check("t1_misalign", dw_misalign, 32'd0);
        check("t1_busy_run", {31'd0, busy}, 32'd0);

        // Test 2: NI=257 is rejected
        do_reset();
        fill_mem();
        send(32'h0101_0000);
        in_valid = 1'b0;
        check("t2_error", {31'd0, error}, 32'd1);
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("t2_writes", iw_cnt + dw_cnt, 32'd0);
        check("t2_start", {31'd0, start}, 32'd0);
        check("t2_error_hold", {31'd0, error}, 32'd1);

        // Test 3: empty image, clear only
        do_reset();
        fill_mem();
        send(32'h0000_0000);
        in_valid = 1'b0;
        t0 = cyc;
        wait_start(n);
        check("t3_latency", cyc - t0, 32'd258);
        check("t3_iw_cnt", iw_cnt, 32'd256);
        check("t3_dw_cnt", dw_cnt, 32'd8);
        check("t3_imem_zero", imem_nonzero(0), 32'd0);
        check("t3_dmem_zero", dmem_nonzero(0), 32'd0);

        // Test 4: NI=2 with valid toggling every other cycle
        do_reset();
        fill_mem();
        send(32'h0002_0000);
        w2[0] = 32'h1111_2222;
        w2[1] = 32'h3333_4444;
        k = 0;
        n = 0;
        while (k < 2 && n < 1000) begin
            in_valid = n[0];
            in_data  = w2[k];
            if (in_valid && in_ready) k++;
            step();
            n++;
        end
        in_valid = 1'b0;
        wait_start(n);
        check("t4_iw_cnt", iw_cnt, 32'd258);
        check("t4_ld0_addr", iw_addr[256], 32'd0);
        check("t4_ld0_data", iw_data[256], 32'h1111_2222);
        check("t4_ld1_addr", iw_addr[257], 32'd1);
        check("t4_ld1_data", iw_data[257], 32'h3333_4444);

        // Test 5: reset mid LOAD_I, then a fresh load
        do_reset();
        fill_mem();
        send(32'h0003_0000);
        in_data = 32'h5555_0000; while (!in_ready) step(); step();
        in_valid = 1'b0;
        check("t5_w0", imem_m[0], 32'h5555_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_outs", {31'd0, |{in_ready, imem_we, imem_addr, imem_data, dmem_we,
                                       dmem_addr, dmem_data, start, busy, error}}, 32'd0);
        fill_mem();
        step();
        step();
        check("t5_no_writes", iw_cnt + dw_cnt, 32'd0);
        send(32'h0001_0001);
        in_data = 32'h7777_8888; while (!in_ready) step(); step();
        in_data = 32'h0000_0099; step();
        in_valid = 1'b0;
        wait_start(n);
        check("t5_imem0", imem_m[0], 32'h7777_8888);
        check("t5_imem_rest", imem_nonzero(1), 32'd0);
        check("t5_dmem0", dmem_m[0], 32'h0000_0099);

        // Test 6: traffic in RUN is ignored
        fill_mem();
        rdy_seen = 1'b0;
        start_drop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
            if (in_ready) rdy_seen = 1'b1;
            if (!start) start_drop = 1'b1;
        end
        in_valid = 1'b0;
        check("t6_ready", {31'd0, rdy_seen}, 32'd0);
        check("t6_writes", iw_cnt + dw_cnt, 32'd0);
        check("t6_start_drop", {31'd0, start_drop}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
